// File: rtl/q_learn_pkg.sv
// Shared types and helpers for the Q-matrix update path.
package q_learn_pkg;

  localparam int Q_W   = 32;
  localparam int ACT_W = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    CALC  = 3'd3,
    WRITE = 3'd4
  } upd_fsm_t;

  // Clamp a 34-bit signed result into the signed 32-bit range.
  function automatic logic [Q_W-1:0] sat34to32(input logic signed [Q_W+1:0] v);
    logic [Q_W-1:0] r;
    if (v[Q_W+1:Q_W-1] == 3'b000 || v[Q_W+1:Q_W-1] == 3'b111) begin
      r = v[Q_W-1:0];
    end else if (v[Q_W+1]) begin
      r = {1'b1, {(Q_W-1){1'b0}}};
    end else begin
      r = {1'b0, {(Q_W-1){1'b1}}};
    end
    return r;
  endfunction

endpackage

// File: rtl/q_delta_calc.sv
// Combinational Q-learning datapath: q_old + alpha*(R + gamma*Qmax' - q_old).
// Q_UPD_SAT_EN selects saturating instead of wrapping 32-bit reduction.
module q_delta_calc
  import q_learn_pkg::*;
#(
  parameter int ALPHA_SHIFT = 2,
  parameter int GAMMA_SHIFT = 3
) (
  input  logic [Q_W-1:0] q_old,
  input  logic [Q_W-1:0] reward,
  input  logic [Q_W-1:0] qmax_next,
  output logic [Q_W-1:0] q_new
);

  logic signed [Q_W+1:0] q_old_x;
  logic signed [Q_W+1:0] reward_x;
  logic signed [Q_W+1:0] qmax_x;
  logic signed [Q_W+1:0] gq;
  logic signed [Q_W+1:0] delta;

  assign q_old_x  = {{2{q_old[Q_W-1]}}, q_old};
  assign reward_x = {{2{reward[Q_W-1]}}, reward};
  assign qmax_x   = {{2{qmax_next[Q_W-1]}}, qmax_next};

  // gamma = 1 - 2^-GAMMA_SHIFT, so gamma*Qmax' needs no multiplier
  assign gq    = qmax_x - (qmax_x >>> GAMMA_SHIFT);
  assign delta = reward_x + gq - q_old_x;

`ifdef Q_UPD_SAT_EN
  logic signed [Q_W+1:0] q_sum;
  assign q_sum = q_old_x + (delta >>> ALPHA_SHIFT);
  assign q_new = sat34to32(q_sum);
`else
  assign q_new = Q_W'(q_old_x + (delta >>> ALPHA_SHIFT));
`endif

endmodule

// File: rtl/q_updater.sv
// Q-matrix writer: read-modify-write of one (state, action) entry per request.
// Build option Q_UPD_SAT_EN enables saturation of the updated value.
//
// state | meaning
// IDLE  | ready for a request, registers request fields on accept
// READ  | RAM read strobe at {state, action}
// WAIT  | RAM data returns, captured into q_old
// CALC  | updated value registered into q_new
// WRITE | done pulse, write back when learning was set
module q_updater
  import q_learn_pkg::*;
#(
  parameter int S_W         = 6,
  parameter int ALPHA_SHIFT = 2,
  parameter int GAMMA_SHIFT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 learning,
  input  logic                 upd_valid,
  output logic                 upd_ready,
  input  logic [S_W-1:0]       upd_state,
  input  logic [ACT_W-1:0]     upd_action,
  input  logic [Q_W-1:0]       upd_reward,
  input  logic [Q_W-1:0]       upd_qmax_next,
  output logic                 mem_rd_en,
  output logic [S_W+ACT_W-1:0] mem_rd_addr,
  input  logic [Q_W-1:0]       mem_rd_data,
  output logic                 mem_wr_en,
  output logic [S_W+ACT_W-1:0] mem_wr_addr,
  output logic [Q_W-1:0]       mem_wr_data,
  output logic                 upd_done,
  output logic [Q_W-1:0]       q_new
);

  upd_fsm_t state, state_nxt;

  logic [S_W-1:0]   state_reg;
  logic [ACT_W-1:0] action_reg;
  logic [Q_W-1:0]   reward_reg;
  logic [Q_W-1:0]   qmax_reg;
  logic             learning_reg;
  logic [Q_W-1:0]   q_old;
  logic [Q_W-1:0]   q_calc;
  logic             accept;

  // Ready is masked while reset is held so nothing is accepted before release
  assign upd_ready = (state == IDLE) & rst_n;
  assign accept    = upd_valid & upd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    upd_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (upd_valid) state_nxt = READ;
      end
      READ: begin
        mem_rd_en = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:  state_nxt = CALC;
      CALC:  state_nxt = WRITE;
      WRITE: begin
        upd_done  = 1'b1;
        mem_wr_en = learning_reg;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= '0;
      action_reg   <= '0;
      reward_reg   <= '0;
      qmax_reg     <= '0;
      learning_reg <= 1'b0;
      q_old        <= '0;
      q_new        <= '0;
    end else begin
      if (accept) begin
        state_reg    <= upd_state;
        action_reg   <= upd_action;
        reward_reg   <= upd_reward;
        qmax_reg     <= upd_qmax_next;
        learning_reg <= learning;
      end
      if (state == WAIT) q_old <= mem_rd_data;
      if (state == CALC) q_new <= q_calc;
    end
  end

  q_delta_calc #(
    .ALPHA_SHIFT(ALPHA_SHIFT),
    .GAMMA_SHIFT(GAMMA_SHIFT)
  ) u_delta_calc (
    .q_old    (q_old),
    .reward   (reward_reg),
    .qmax_next(qmax_reg),
    .q_new    (q_calc)
  );

  assign mem_rd_addr = {state_reg, action_reg};
  assign mem_wr_addr = {state_reg, action_reg};
  assign mem_wr_data = q_new;

endmodule

// File: tb/tb_q_updater.sv
// Directed bench for q_updater with a behavioural 1-cycle-latency Q RAM.
module tb_q_updater;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        learning;
  logic        upd_valid;
  logic        upd_ready;
  logic [5:0]  upd_state;
  logic [1:0]  upd_action;
  logic [31:0] upd_reward;
  logic [31:0] upd_qmax_next;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        mem_wr_en;
  logic [7:0]  mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        upd_done;
  logic [31:0] q_new;

  always #5 clk = ~clk;

  q_updater #(.S_W(6), .ALPHA_SHIFT(2), .GAMMA_SHIFT(3)) dut (
    .clk(clk), .rst_n(rst_n), .learning(learning),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_state(upd_state), .upd_action(upd_action),
    .upd_reward(upd_reward), .upd_qmax_next(upd_qmax_next),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .upd_done(upd_done), .q_new(q_new)
  );

  // RAM model; pl_* is a bench-side preload port
  logic [31:0] ram [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
    mem_rd_data <= mem_rd_en ? ram[mem_rd_addr] : 32'hDEAD_BEEF;
  end

  int cyc = 0, acc_cnt = 0, acc_cyc = 0;
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, done_lat = 0, ovl_cnt = 0;
  int busy_run = 0, busy_seen = 0, busy_bad = 0;
  logic        track = 1'b0;
  logic        rd_prev = 1'b0;
  logic        done_wr_en = 1'b0;
  logic [7:0]  done_addr = '0;
  logic [31:0] done_data = '0;
  logic [7:0]  rd_addr_seen = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && upd_valid && upd_ready) begin
      acc_cnt <= acc_cnt + 1;
      acc_cyc <= cyc;
    end
  end

  always @(negedge clk) begin
    if (mem_rd_en) begin
      rd_cnt       <= rd_cnt + 1;
      rd_addr_seen <= mem_rd_addr;
    end
    if (mem_wr_en) wr_cnt <= wr_cnt + 1;
    if (upd_done) begin
      done_cnt   <= done_cnt + 1;
      done_lat   <= cyc - acc_cyc;
      done_wr_en <= mem_wr_en;
      done_addr  <= mem_wr_addr;
      done_data  <= mem_wr_data;
    end
    if (upd_ready && (upd_done || mem_rd_en || mem_wr_en)) ovl_cnt <= ovl_cnt + 1;
    if (mem_rd_en && rd_prev) ovl_cnt <= ovl_cnt + 1;
    rd_prev <= mem_rd_en;
    if (!upd_ready && rst_n) begin
      busy_run <= busy_run + 1;
    end else begin
      if (track && busy_run != 0) begin
        busy_seen <= busy_seen + 1;
        if (busy_run != 4) busy_bad <= busy_bad + 1;
      end
      busy_run <= 0;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ram_load(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one request, scramble inputs after accept, wait for done
  task automatic run_upd(input logic [5:0] s, input logic [1:0] a, input logic [31:0] r,
                         input logic [31:0] q, input logic l);
    int a0, d0;
    a0 = acc_cnt;
    d0 = done_cnt;
    @(negedge clk);
    upd_state = s; upd_action = a; upd_reward = r; upd_qmax_next = q; learning = l;
    upd_valid = 1'b1;
    for (int i = 0; i < 10 && acc_cnt == a0; i++) @(negedge clk);
    upd_valid = 1'b0;
    upd_state = ~s; upd_action = ~a; upd_reward = 32'h1234_5678;
    upd_qmax_next = 32'h7654_3210; learning = ~l;
    for (int i = 0; i < 20 && done_cnt == d0; i++) @(negedge clk);
    chk("done_seen", 32'(done_cnt - d0), 32'd1);
  endtask

  logic [31:0] ovf_exp;
  int a0, d0, r0, w0;

  initial begin
    learning = 1'b0; upd_valid = 1'b0; upd_state = '0; upd_action = '0;
    upd_reward = '0; upd_qmax_next = '0;
    repeat (2) @(negedge clk);
    chk("ready_in_reset", 32'(upd_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(upd_ready), 32'd1);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_done", 32'(upd_done), 32'd0);
    chk("rst_q_new", q_new, 32'h0);
    chk("rst_wr_data", mem_wr_data, 32'h0);
    chk("rst_rd_addr", 32'(mem_rd_addr), 32'h0);

    // basic update at {5,2}
    ram_load(8'h16, 32'h0001_0000);
    w0 = wr_cnt;
    run_upd(6'd5, 2'd2, 32'h0002_0000, 32'h0000_8000, 1'b1);
    chk("basic_latency", 32'(done_lat), 32'd4);
    chk("basic_rd_addr", 32'(rd_addr_seen), 32'h16);
    chk("basic_wr_en", 32'(done_wr_en), 32'd1);
    chk("basic_wr_addr", 32'(done_addr), 32'h16);
    chk("basic_wr_data", done_data, 32'h0001_5C00);
    chk("basic_wr_count", 32'(wr_cnt - w0), 32'd1);
    chk("basic_q_new", q_new, 32'h0001_5C00);
    chk("basic_ram", ram[8'h16], 32'h0001_5C00);

    // learning disabled
    ram_load(8'h16, 32'h0001_0000);
    w0 = wr_cnt;
    run_upd(6'd5, 2'd2, 32'h0002_0000, 32'h0000_8000, 1'b0);
    chk("nolearn_wr_count", 32'(wr_cnt - w0), 32'd0);
    chk("nolearn_ram", ram[8'h16], 32'h0001_0000);
    chk("nolearn_q_new", q_new, 32'h0001_5C00);

    // overflow
`ifdef Q_UPD_SAT_EN
    ovf_exp = 32'h7FFF_FFFF;
`else
    ovf_exp = 32'h9BFE_C800;
`endif
    ram_load(8'h25, 32'h7FFF_0000);
    run_upd(6'd9, 2'd1, 32'h7FFF_0000, 32'h7FFF_0000, 1'b1);
    chk("ovf_wr_data", done_data, ovf_exp);
    chk("ovf_ram", ram[8'h25], ovf_exp);

    // negative delta
    ram_load(8'hFF, 32'h0004_0000);
    run_upd(6'd63, 2'd3, 32'hFFFF_0000, 32'h0000_0000, 1'b1);
    chk("neg_wr_addr", 32'(done_addr), 32'hFF);
    chk("neg_wr_data", done_data, 32'h0002_C000);

    // upd_valid held for 12 cycles: chained updates on {3,1}
    ram_load(8'h0D, 32'h0000_0000);
    a0 = acc_cnt; d0 = done_cnt; r0 = rd_cnt;
    @(negedge clk);
    track = 1'b1;
    upd_state = 6'd3; upd_action = 2'd1; upd_reward = 32'h0004_0000;
    upd_qmax_next = 32'h0; learning = 1'b1; upd_valid = 1'b1;
    repeat (12) @(negedge clk);
    upd_valid = 1'b0;
    for (int i = 0; i < 20 && done_cnt < d0 + 3; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    track = 1'b0;
    chk("held_accepts", 32'(acc_cnt - a0), 32'd3);
    chk("held_dones", 32'(done_cnt - d0), 32'd3);
    chk("held_reads", 32'(rd_cnt - r0), 32'd3);
    chk("held_busy_runs", 32'(busy_seen), 32'd3);
    chk("held_busy_len_bad", 32'(busy_bad), 32'd0);
    chk("held_ram", ram[8'h0D], 32'h0002_5000);

    // reset during CALC
    ram_load(8'h1C, 32'h0003_0000);
    a0 = acc_cnt; d0 = done_cnt; w0 = wr_cnt;
    @(negedge clk);
    upd_state = 6'd7; upd_action = 2'd0; upd_reward = 32'h0002_0000;
    upd_qmax_next = 32'h0000_8000; learning = 1'b1; upd_valid = 1'b1;
    for (int i = 0; i < 10 && acc_cnt == a0; i++) @(negedge clk);
    upd_valid = 1'b0;
    chk("rstcalc_accepted", 32'(acc_cnt - a0), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstcalc_ready", 32'(upd_ready), 32'd1);
    chk("rstcalc_q_new", q_new, 32'h0);
    repeat (6) @(negedge clk);
    chk("rstcalc_no_write", 32'(wr_cnt - w0), 32'd0);
    chk("rstcalc_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rstcalc_ram", ram[8'h1C], 32'h0003_0000);

    ram_load(8'h1C, 32'h0001_0000);
    run_upd(6'd7, 2'd0, 32'h0002_0000, 32'h0000_8000, 1'b1);
    chk("after_rst_wr_data", done_data, 32'h0001_5C00);
    chk("after_rst_ram", ram[8'h1C], 32'h0001_5C00);

    chk("no_overlap", 32'(ovl_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
